pwm_deadtime: RTL and testbench

- Dead-time insertion stage directly downstream of the timer's PWM output.
- Converts the single-ended PWM into a complementary high-side/low-side pair (OutH/OutL), guaranteeing a programmable both-off gap at every transition.
- Adds a latched trap (fault) shutdown that forces both outputs off until software clears it.
- Same clock domain as the timer; no input synchronisation needed.

---
 rtl/pwm_deadtime.sv | 158 +++++++++++++++
 tb/tb_pwm_deadtime.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the timer's single-ended PWM into a complementary
// OutH/OutL drive pair with a programmable both-off gap at every transition.
// A latched trap shutdown is built in when PWMDT_TRAP_EN is defined; without
// it TrapIn/TrapClr are ignored and TrapFlag reads 0.
// All outputs are registered and decoded from the next state, so OutH and
// OutL can never be high together. That holds across async reset too.
module pwm_deadtime #(
  parameter int DTW = 8
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           En,
  input  logic           PwmIn,
  input  logic [DTW-1:0] DtRise,
  input  logic [DTW-1:0] DtFall,
  input  logic           TrapIn,
  input  logic           TrapClr,
  output logic           OutH,
  output logic           OutL,
  output logic           DtActive,
  output logic           TrapFlag
);

`ifdef PWMDT_TRAP_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DT_H = 3'd1,
    H_ON = 3'd2,
    DT_L = 3'd3,
    L_ON = 3'd4,
    TRAP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DT_H = 3'd1,
    H_ON = 3'd2,
    DT_L = 3'd3,
    L_ON = 3'd4
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [DTW-1:0] cnt_q, cnt_d;
  logic           out_h_q, out_l_q, dt_act_q;

  // Next-state and dead-time counter logic. Trap outranks enable, and
  // enable outranks the PWM edge handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PWMDT_TRAP_EN
    if (state_q == TRAP) begin
      if (TrapClr && !TrapIn) begin
        state_d = IDLE;
      end
      cnt_d = '0;
    end else if (TrapIn) begin
      state_d = TRAP;
      cnt_d   = '0;
    end else
`endif
    if (!En) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (PwmIn) begin
            state_d = DT_H;
            cnt_d   = DtRise;
          end else begin
            state_d = DT_L;
            cnt_d   = DtFall;
          end
        end
        DT_H: begin
          // A PWM pulse that ends inside the gap never reaches OutH.
          if (!PwmIn) begin
            state_d = DT_L;
            cnt_d   = DtFall;
          end else if (cnt_q == '0) begin
            state_d = H_ON;
          end else begin
            cnt_d = cnt_q - DTW'(1);
          end
        end
        H_ON: begin
          if (!PwmIn) begin
            state_d = DT_L;
            cnt_d   = DtFall;
          end
        end
        DT_L: begin
          if (PwmIn) begin
            state_d = DT_H;
            cnt_d   = DtRise;
          end else if (cnt_q == '0) begin
            state_d = L_ON;
          end else begin
            cnt_d = cnt_q - DTW'(1);
          end
        end
        L_ON: begin
          if (PwmIn) begin
            state_d = DT_H;
            cnt_d   = DtRise;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers; outputs decoded from next state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_h_q  <= 1'b0;
      out_l_q  <= 1'b0;
      dt_act_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_h_q  <= (state_d == H_ON);
      out_l_q  <= (state_d == L_ON);
      dt_act_q <= (state_d == DT_H) || (state_d == DT_L);
    end
  end

  assign OutH     = out_h_q;
  assign OutL     = out_l_q;
  assign DtActive = dt_act_q;

`ifdef PWMDT_TRAP_EN
  logic trap_flag_q;

  // Sticky trap status follows the TRAP state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      trap_flag_q <= 1'b0;
    end else begin
      trap_flag_q <= (state_d == TRAP);
    end
  end

  assign TrapFlag = trap_flag_q;
`else
  logic unused_trap;
  assign unused_trap = ^{TrapIn, TrapClr};
  assign TrapFlag    = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: dead-time gaps, short-pulse suppression,
// dead-time reload timing, enable, trap (when PWMDT_TRAP_EN) and async reset.
module tb_pwm_deadtime;

  localparam int DTW = 8;

  logic           Clk = 1'b0;
  logic           Rst;
  logic           En;
  logic           PwmIn;
  logic [DTW-1:0] DtRise;
  logic [DTW-1:0] DtFall;
  logic           TrapIn;
  logic           TrapClr;
  logic           OutH;
  logic           OutL;
  logic           DtActive;
  logic           TrapFlag;

  int n_checks = 0;
  int n_errors = 0;
  bit both_seen = 1'b0;

  pwm_deadtime #(.DTW(DTW)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .En      (En),
    .PwmIn   (PwmIn),
    .DtRise  (DtRise),
    .DtFall  (DtFall),
    .TrapIn  (TrapIn),
    .TrapClr (TrapClr),
    .OutH    (OutH),
    .OutL    (OutL),
    .DtActive(DtActive),
    .TrapFlag(TrapFlag)
  );

  always #5 Clk = ~Clk;

  // Watch for overlap at any instant, not just at sample points.
  always @(OutH or OutL) begin
    if (OutH && OutL) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Step until the target output rises; report edges taken, DtActive cycles
  // seen, and whether the opposite output was ever high meanwhile.
  task automatic wait_out(input bit hi, output int cycles, output int dtcnt, output bit other_hi);
    cycles   = 0;
    dtcnt    = 0;
    other_hi = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      cycles++;
      if (DtActive) dtcnt++;
      if (hi ? OutL : OutH) other_hi = 1'b1;
      if (hi ? OutH : OutL) break;
    end
  endtask

  int cycles, dtcnt;
  bit other_hi;

  initial begin
    Rst = 1'b1; En = 1'b0; PwmIn = 1'b0;
    DtRise = 8'd4; DtFall = 8'd4;
    TrapIn = 1'b0; TrapClr = 1'b0;

    // Reset state
    cyc(2);
    check("rst_outh", OutH, 0);
    check("rst_outl", OutL, 0);
    check("rst_dtact", DtActive, 0);
    check("rst_trapflag", TrapFlag, 0);
    Rst = 1'b0;
    cyc(1);
    check("idle_en0_outl", OutL, 0);
    check("idle_en0_dtact", DtActive, 0);

    // Start-up from IDLE with PwmIn low: DT_L for 5 cycles then L_ON
    En = 1'b1;
    wait_out(1'b0, cycles, dtcnt, other_hi);
    check("start_cycles", cycles, 6);
    check("start_dtcnt", dtcnt, 5);

    // Toggle every 20 cycles with 4/4 dead time
    for (int k = 0; k < 4; k++) begin
      PwmIn = ~PwmIn;
      wait_out(PwmIn, cycles, dtcnt, other_hi);
      check("tog_cycles", cycles, 6);
      check("tog_dtcnt", dtcnt, 5);
      check("tog_other", other_hi, 0);
      cyc(14);
      check("tog_hold_h", OutH, PwmIn);
      check("tog_hold_l", OutL, !PwmIn);
    end

    // DtFall=0: one-cycle both-low gap
    PwmIn = 1'b1;
    wait_out(1'b1, cycles, dtcnt, other_hi);
    DtFall = 8'd0;
    PwmIn  = 1'b0;
    cyc(1);
    check("dt0_outh_n1", OutH, 0);
    check("dt0_outl_n1", OutL, 0);
    check("dt0_dtact_n1", DtActive, 1);
    cyc(1);
    check("dt0_outl_n2", OutL, 1);
    check("dt0_dtact_n2", DtActive, 0);

    // Short pulse: DtRise=6, PwmIn high for 3 cycles is swallowed
    DtRise = 8'd6;
    DtFall = 8'd2;
    PwmIn  = 1'b1;
    cyc(3);
    check("short_outh", OutH, 0);
    check("short_outl", OutL, 0);
    check("short_dtact", DtActive, 1);
    PwmIn = 1'b0;
    wait_out(1'b0, cycles, dtcnt, other_hi);
    check("short_ret_cycles", cycles, 4);
    check("short_ret_dtcnt", dtcnt, 3);
    check("short_never_h", other_hi, 0);

    // DtRise changed mid-gap: current gap stays 3 cycles, next one is 11
    DtRise = 8'd2;
    PwmIn  = 1'b1;
    cyc(1);
    check("reload_first_dt", DtActive, 1);
    DtRise = 8'd10;
    wait_out(1'b1, cycles, dtcnt, other_hi);
    check("reload_cur_cycles", cycles, 3);
    check("reload_cur_dtcnt", dtcnt, 2);
    DtFall = 8'd0;
    PwmIn  = 1'b0;
    wait_out(1'b0, cycles, dtcnt, other_hi);
    check("reload_fall_cycles", cycles, 2);
    PwmIn = 1'b1;
    wait_out(1'b1, cycles, dtcnt, other_hi);
    check("reload_next_cycles", cycles, 12);
    check("reload_next_dtcnt", dtcnt, 11);

`ifdef PWMDT_TRAP_EN
    // Trap from H_ON
    TrapIn = 1'b1;
    cyc(1);
    check("trap_outh", OutH, 0);
    check("trap_outl", OutL, 0);
    check("trap_flag", TrapFlag, 1);
    TrapClr = 1'b1;
    cyc(1);
    check("trap_clr_ignored", TrapFlag, 1);
    TrapIn  = 1'b0;
    TrapClr = 1'b0;
    cyc(2);
    check("trap_sticky", TrapFlag, 1);
    check("trap_sticky_outh", OutH, 0);
    TrapClr = 1'b1;
    cyc(1);
    TrapClr = 1'b0;
    check("trap_cleared", TrapFlag, 0);
    check("trap_idle_dtact", DtActive, 0);
    cyc(1);
    check("trap_reentry_dth", DtActive, 1);
    wait_out(1'b1, cycles, dtcnt, other_hi);
    check("trap_reentry_cycles", cycles, 11);
    // Simultaneous TrapIn and TrapClr outside TRAP still traps
    TrapIn  = 1'b1;
    TrapClr = 1'b1;
    cyc(1);
    check("trap_simul_flag", TrapFlag, 1);
    check("trap_simul_outh", OutH, 0);
    TrapIn = 1'b0;
    cyc(1);
    TrapClr = 1'b0;
    check("trap_simul_clr", TrapFlag, 0);
`else
    // Trap inputs are ignored in this build
    TrapIn  = 1'b1;
    TrapClr = 1'b1;
    cyc(1);
    TrapIn  = 1'b0;
    TrapClr = 1'b0;
    check("notrap_outh", OutH, 1);
    check("notrap_flag", TrapFlag, 0);
`endif
    DtRise = 8'd3;
    wait_out(1'b1, cycles, dtcnt, other_hi);
    check("pre_en_outh", OutH, 1);

    // En=0 forces IDLE; re-enable walks the full rising gap
    En = 1'b0;
    cyc(1);
    check("en0_outh", OutH, 0);
    check("en0_outl", OutL, 0);
    check("en0_dtact", DtActive, 0);
    En = 1'b1;
    wait_out(1'b1, cycles, dtcnt, other_hi);
    check("en1_cycles", cycles, 5);
    check("en1_dtcnt", dtcnt, 4);

    // Async reset mid DT_L, away from the clock edge
    DtFall = 8'd10;
    PwmIn  = 1'b0;
    cyc(2);
    check("arst_pre_dtact", DtActive, 1);
    #3 Rst = 1'b1;
    #1;
    check("arst_dtl_dtact", DtActive, 0);
    check("arst_dtl_outl", OutL, 0);
    #2 Rst = 1'b0;

    // Async reset in H_ON
    DtRise = 8'd1;
    PwmIn  = 1'b1;
    wait_out(1'b1, cycles, dtcnt, other_hi);
    check("arst_hon_cycles", cycles, 3);
    #4 Rst = 1'b1;
    #1;
    check("arst_hon_outh", OutH, 0);
    #1 Rst = 1'b0;
    cyc(2);

    check("never_both", both_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
